// File: rtl/tissue_pkg.sv
// Shared types and constants for the tissue loader.
// Holds the FSM encoding and the Weyl seed stride.
package tissue_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_SHIFT,
    S_RUN,
    S_DONE
  } state_t;

  // Golden-ratio bits; the top W bits give an odd Weyl stride.
  localparam logic [63:0] GOLDEN = 64'h9E3779B97F4A7C15;

  localparam logic [15:0] SEED_STRIDE = 16'h9E37;
  localparam int SEED_ZERO_SUB = 1;

endpackage

// File: rtl/tissue_loader_seed_gen.sv
// Weyl-sequence seed accumulator for per-cell LFSR seeds.
// A zero sum is replaced so no cell LFSR locks up.
module seed_gen
  import tissue_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] cfg_seed,
  input  logic         step,
  output logic [W-1:0] seed
);

  localparam logic [W-1:0] STRIDE =
    (W == 16) ? W'(SEED_STRIDE) : (GOLDEN[63 -: W] | W'(1));

  logic [W-1:0] acc;

  // Accumulator: load base seed, then add stride per shift cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (load) begin
      acc <= cfg_seed;
    end else if (step) begin
      acc <= acc + STRIDE;
    end
  end

  assign seed = (acc == '0) ? W'(SEED_ZERO_SUB) : acc;

endmodule

// File: rtl/tissue_loader.sv
// Buffers the host tissue image and bursts it into the
// tissue init chain with config and per-cell seeds.
module tissue_loader
  import tissue_pkg::*;
#(
  parameter int TISSUE_WIDTH   = 90,
  parameter int TISSUE_HEIGHT  = 3,
  parameter int NUM_STATUS     = 8,
  parameter int RANDOMIZED_LEN = 2,
  localparam int N  = TISSUE_WIDTH * TISSUE_HEIGHT,
  localparam int T  = 2 ** (NUM_STATUS + 1),
  localparam int W  = RANDOMIZED_LEN * 8,
  localparam int CW = $clog2(N + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] cfg_chance,
  input  logic [T-1:0] cfg_logic,
  input  logic [W-1:0] cfg_seed,
  input  logic [32:0]  cfg_steps,
  input  logic         s_valid,
  input  logic         s_data,
  output logic         s_ready,
  output logic         tis_rst,
  output logic         tis_init,
  output logic         tis_status,
  output logic [W-1:0] tis_chance,
  output logic [T-1:0] tis_logic,
  output logic [W-1:0] tis_seed,
  output logic [32:0]  tis_steps,
  input  logic         tis_done,
  output logic         busy,
  output logic         finished
);

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [N-1:0]  cell_buf;
  logic [W-1:0]  seed;
  logic          start_ok;
  logic          beat;
  logic          last_beat;
  logic          shift_last;
  logic          seed_load;
  logic          seed_step;

  assign start_ok   = start && (state == S_IDLE || state == S_DONE);
  assign beat       = s_valid && s_ready;
  assign last_beat  = beat && (cnt == CW'(N - 1));
  assign shift_last = (state == S_SHIFT) && (cnt == CW'(N - 1));
  assign seed_load  = start_ok && !abort;
  assign seed_step  = !abort &&
                      (last_beat || (state == S_SHIFT && !shift_last));

  seed_gen #(
    .W(W)
  ) u_seed (
    .clk     (clk),
    .rst     (rst),
    .load    (seed_load),
    .cfg_seed(cfg_seed),
    .step    (seed_step),
    .seed    (seed)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state; abort overrides everything, including start.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE, S_DONE: if (start) state_nx = S_FILL;
      S_FILL:         if (last_beat) state_nx = S_SHIFT;
      S_SHIFT:        if (shift_last) state_nx = S_RUN;
      S_RUN:          if (tis_done) state_nx = S_DONE;
      default:        state_nx = S_IDLE;
    endcase
    if (abort) state_nx = S_IDLE;
  end

  // Registered outputs, counter, config latch and chain driver.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_ready    <= 1'b0;
      tis_rst    <= 1'b1;
      tis_init   <= 1'b0;
      busy       <= 1'b0;
      finished   <= 1'b0;
      tis_status <= 1'b0;
      tis_seed   <= '0;
      tis_chance <= '0;
      tis_logic  <= '0;
      tis_steps  <= '0;
      cnt        <= '0;
    end else begin
      s_ready  <= (state_nx == S_FILL);
      tis_init <= (state_nx == S_SHIFT);
      tis_rst  <= (state_nx == S_IDLE);
      busy     <= (state_nx != S_IDLE) && (state_nx != S_DONE);
      finished <= (state_nx == S_DONE);
      if (abort) begin
        cnt <= '0;
      end else if (start_ok) begin
        tis_chance <= cfg_chance;
        tis_logic  <= cfg_logic;
        tis_steps  <= cfg_steps;
        cnt        <= '0;
      end else if (beat) begin
        if (last_beat) begin
          cnt        <= '0;
          tis_status <= s_data;
          tis_seed   <= seed;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else if (state == S_SHIFT) begin
        if (shift_last) begin
          cnt        <= '0;
          tis_status <= 1'b0;
        end else begin
          cnt        <= cnt + CW'(1);
          tis_status <= cell_buf[N-2];
          tis_seed   <= seed;
        end
      end
    end
  end

  // Image buffer: filled by index, drained MSB-first by shifting.
  always_ff @(posedge clk) begin
    if (beat) begin
      cell_buf[cnt] <= s_data;
    end else if (state == S_SHIFT) begin
      cell_buf <= {cell_buf[N-2:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_tissue_loader.sv
// Self-checking bench for tissue_loader.
// Table-driven loads plus hand-written reset/run/abort sequences.
module tb_tissue_loader;

  localparam int N = 270;
  localparam int W = 16;
  localparam int T = 512;
  localparam logic [15:0] STRIDE = 16'h9E37;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] cfg_chance = '0;
  logic [T-1:0] cfg_logic = '0;
  logic [W-1:0] cfg_seed = '0;
  logic [32:0]  cfg_steps = '0;
  logic         s_valid = 1'b0;
  logic         s_data = 1'b0;
  logic         s_ready;
  logic         tis_rst;
  logic         tis_init;
  logic         tis_status;
  logic [W-1:0] tis_chance;
  logic [T-1:0] tis_logic;
  logic [W-1:0] tis_seed;
  logic [32:0]  tis_steps;
  logic         tis_done = 1'b0;
  logic         busy;
  logic         finished;

  tissue_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .cfg_chance(cfg_chance),
    .cfg_logic (cfg_logic),
    .cfg_seed  (cfg_seed),
    .cfg_steps (cfg_steps),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .tis_rst   (tis_rst),
    .tis_init  (tis_init),
    .tis_status(tis_status),
    .tis_chance(tis_chance),
    .tis_logic (tis_logic),
    .tis_seed  (tis_seed),
    .tis_steps (tis_steps),
    .tis_done  (tis_done),
    .busy      (busy),
    .finished  (finished)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] seed;
    int          mode;
    int          vpct;
    logic [32:0] steps;
    bit          has_first;
    logic        first;
    int          k0;
    int          k1;
    int          k2;
    logic [15:0] v0;
    logic [15:0] v1;
    logic [15:0] v2;
  } vec_t;

  logic [N-1:0] got_bits;
  logic [15:0]  got_seed [N+2];
  int           got_len;
  logic [W-1:0] exp_chance;
  logic [T-1:0] exp_logic;
  logic [32:0]  exp_steps;

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic check_wide(input string name, input logic [T-1:0] got,
                            input logic [T-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] seed_model(input logic [15:0] base,
                                             input int j);
    logic [31:0] v;
    v = 32'(base) + 32'(j) * 32'(STRIDE);
    return (v[15:0] == 16'h0) ? 16'h0001 : v[15:0];
  endfunction

  function automatic logic [N-1:0] make_pat(input int mode);
    logic [N-1:0] p;
    for (int k = 0; k < N; k++) begin
      if (mode == 0) p[k] = 1'(k % 2);
      else if (mode == 1) p[k] = 1'($urandom_range(1));
      else p[k] = 1'b1;
    end
    return p;
  endfunction

  task automatic rand_cfg();
    cfg_chance = 16'($urandom);
    for (int i = 0; i < T / 32; i++) cfg_logic[i*32 +: 32] = $urandom;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_tis_rst"}, 64'(tis_rst), 64'd1);
    check({tag, "_tis_init"}, 64'(tis_init), 64'd0);
    check({tag, "_s_ready"}, 64'(s_ready), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_finished"}, 64'(finished), 64'd0);
    check({tag, "_status"}, 64'(tis_status), 64'd0);
    check({tag, "_seed"}, 64'(tis_seed), 64'd0);
    check({tag, "_chance"}, 64'(tis_chance), 64'd0);
    check({tag, "_steps"}, 64'(tis_steps), 64'd0);
    check_wide({tag, "_logic"}, tis_logic, '0);
  endtask

  // Start a load, stream pat with given valid rate, collect the burst.
  // abort_at >= 0 aborts (with a simultaneous start) on that shift cycle.
  task automatic run_load(input logic [15:0] sd, input logic [N-1:0] pat,
                          input int vpct, input logic [32:0] steps,
                          input int abort_at);
    int idx;
    int cyc;
    @(negedge clk);
    rand_cfg();
    cfg_seed   = sd;
    cfg_steps  = steps;
    exp_chance = cfg_chance;
    exp_logic  = cfg_logic;
    exp_steps  = steps;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ready_after_start", 64'(s_ready), 64'd1);
    check("busy_in_fill", 64'(busy), 64'd1);
    idx = 0;
    cyc = 0;
    while (idx < N && cyc < 5000) begin
      s_valid  = ($urandom_range(99) < 32'(vpct));
      s_data   = s_valid ? pat[idx] : 1'($urandom_range(1));
      start    = (idx == 10);
      tis_done = (idx == 20);
      if (idx == 10) begin
        cfg_chance = ~exp_chance;
        cfg_logic  = ~exp_logic;
        cfg_steps  = ~exp_steps;
        cfg_seed   = ~sd;
      end
      if (s_valid && s_ready) idx++;
      @(negedge clk);
      cyc++;
    end
    start    = 1'b0;
    tis_done = 1'b0;
    s_valid  = 1'b0;
    check("fill_beats", 64'(idx), 64'(N));
    check("ready_drop", 64'(s_ready), 64'd0);
    check("init_start", 64'(tis_init), 64'd1);
    got_len  = 0;
    got_bits = '0;
    while (tis_init && got_len < N + 2) begin
      if (got_len < N) got_bits[N-1-got_len] = tis_status;
      got_seed[got_len] = tis_seed;
      if (got_len == abort_at) begin
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        check("abort_init", 64'(tis_init), 64'd0);
        check("abort_tis_rst", 64'(tis_rst), 64'd1);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_ready", 64'(s_ready), 64'd0);
        @(negedge clk);
        check("abort_beats_start", 64'(s_ready), 64'd0);
        got_len++;
        return;
      end
      got_len++;
      @(negedge clk);
    end
    check("init_len", 64'(got_len), 64'(N));
    check("run_tis_rst", 64'(tis_rst), 64'd0);
    check("run_busy", 64'(busy), 64'd1);
    check("run_finished", 64'(finished), 64'd0);
    check("latched_chance", 64'(tis_chance), 64'(exp_chance));
    check("latched_steps", 64'(tis_steps), 64'(exp_steps));
    check_wide("latched_logic", tis_logic, exp_logic);
  endtask

  initial begin
    vec_t         vt [4];
    logic [N-1:0] pat;
    int           nbad;

    vt[0] = '{16'h0001, 0, 100, 33'd10, 1'b1, 1'b1, 0, 1, 2,
              16'h0001, 16'h9E38, 16'h3C6F};
    vt[1] = '{16'h0000, 1, 50, 33'd77, 1'b0, 1'b0, 0, 1, 2,
              16'h0001, 16'h9E37, 16'h3C6E};
    vt[2] = '{16'hE8ED, 2, 70, 33'h1_0000_0001, 1'b1, 1'b1, 4, 5, 6,
              16'h61C9, 16'h0001, 16'h9E37};
    vt[3] = '{16'($urandom), 1, 30, 33'($urandom), 1'b0, 1'b0, -1, -1, -1,
              16'h0, 16'h0, 16'h0};

    repeat (3) @(negedge clk);
    check_reset_vals("por");
    rst = 1'b1;
    @(negedge clk);
    check("idle_ready", 64'(s_ready), 64'd0);
    check("idle_tis_rst", 64'(tis_rst), 64'd1);

    // Reset asserted mid-fill.
    rand_cfg();
    cfg_steps = 33'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    s_valid = 1'b1;
    repeat (50) begin
      s_data = 1'($urandom_range(1));
      @(negedge clk);
    end
    s_valid = 1'b0;
    rst = 1'b0;
    #1;
    check_reset_vals("midfill_rst");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 64'(s_ready), 64'd0);
    check("post_rst_busy", 64'(busy), 64'd0);
    check("post_rst_tis_rst", 64'(tis_rst), 64'd1);

    for (int v = 0; v < 4; v++) begin
      pat = make_pat(vt[v].mode);
      run_load(vt[v].seed, pat, vt[v].vpct, vt[v].steps, -1);
      check_wide("image", T'(got_bits), T'(pat));
      if (vt[v].has_first)
        check("first_bit", 64'(got_bits[N-1]), 64'(vt[v].first));
      if (vt[v].k0 >= 0) begin
        check("seed_k0", 64'(got_seed[vt[v].k0]), 64'(vt[v].v0));
        check("seed_k1", 64'(got_seed[vt[v].k1]), 64'(vt[v].v1));
        check("seed_k2", 64'(got_seed[vt[v].k2]), 64'(vt[v].v2));
      end
      nbad = 0;
      for (int j = 0; j < N; j++) begin
        if (got_seed[j] !== seed_model(vt[v].seed, j)) begin
          if (nbad < 4)
            $display("FAIL seed_seq j=%0d got=%h exp=%h", j,
                     got_seed[j], seed_model(vt[v].seed, j));
          nbad++;
        end
      end
      check("seed_seq_errors", 64'(nbad), 64'd0);
      if (v == 0) begin
        repeat (3) @(negedge clk);
        check("run_wait_finished", 64'(finished), 64'd0);
        check("run_steps", 64'(tis_steps), 64'd10);
        tis_done = 1'b1;
        @(negedge clk);
        tis_done = 1'b0;
        check("done_finished", 64'(finished), 64'd1);
        check("done_busy", 64'(busy), 64'd0);
        check("done_tis_rst", 64'(tis_rst), 64'd0);
        @(negedge clk);
        check("done_holds", 64'(finished), 64'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_ready", 64'(s_ready), 64'd1);
        check("restart_finished", 64'(finished), 64'd0);
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("to_idle_busy", 64'(busy), 64'd0);
      check("to_idle_tis_rst", 64'(tis_rst), 64'd1);
    end

    // Abort together with start on shift cycle 100.
    pat = make_pat(1);
    run_load(16'h1234, pat, 100, 33'd3, 100);
    check("abort_shift_cycles", 64'(got_len), 64'd101);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
